// File: rtl/uart_instr_assembler_if.sv
// Bundle between the UART receive byte engine, the framer and the Core
// instruction port. The byte engine side drives rx_*; the framer drives the
// instruction/error side.
interface uart_instr_assembler_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic        instr_valid;
  logic [15:0] instr;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  // Byte source / instruction consumer side (e.g. a testbench or wrapper)
  modport master (
    output rx_valid,
    output rx_data,
    output rx_err,
    input  instr_valid,
    input  instr,
    input  frame_err,
    input  err_count,
    input  busy
  );

  // Framer side
  modport slave (
    input  rx_valid,
    input  rx_data,
    input  rx_err,
    output instr_valid,
    output instr,
    output frame_err,
    output err_count,
    output busy
  );
endinterface

// File: rtl/uart_instr_assembler.sv
// Byte-to-instruction framer. Hunts for SYNC_BYTE, then collects HI, LO and
// an XOR checksum. Good frames produce a one-cycle instr_valid pulse with the
// 16-bit instruction; corrupt, aborted (rx_err) or stalled (timeout) frames
// produce a one-cycle frame_err pulse and bump a saturating error counter.
// Every output is a flop so the Core sees clean, glitch-free strobes.
module uart_instr_assembler #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000   // must be >= 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  uart_instr_assembler_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  // Idle-counter value at which a further idle cycle abandons the frame.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2,
    WAIT_CHK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic [15:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // A byte only counts when the byte engine did not flag it as corrupt.
  logic byte_ok;
  // Set whenever the current frame is being thrown away with an error.
  logic drop;

  assign byte_ok = bus.rx_valid & ~bus.rx_err;

  // Register all state and outputs; reset is asynchronous to kill a partial
  // frame immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HUNT;
      hi_q          <= 8'h00;
      lo_q          <= 8'h00;
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_count_q   <= 8'h00;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      frame_err_q   <= frame_err_d;
      err_count_q   <= err_count_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, byte capture, checksum decision, timeout and error bookkeeping.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_count_d   = err_count_q;
    cnt_d         = cnt_q;
    drop          = 1'b0;

    if (bus.rx_err) begin
      // A line error always wins, even over a checksum byte in the same cycle.
      // In HUNT there is no frame to lose, so it is silent there.
      state_d = HUNT;
      drop    = (state_q != HUNT);
    end else if (bus.rx_valid) begin
      // A real byte always beats a timeout that would fire this cycle.
      unique case (state_q)
        HUNT: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_d = WAIT_HI;
          end
        end
        WAIT_HI: begin
          // A sync-valued byte here is data; no resynchronisation.
          hi_d    = bus.rx_data;
          state_d = WAIT_LO;
        end
        WAIT_LO: begin
          lo_d    = bus.rx_data;
          state_d = WAIT_CHK;
        end
        WAIT_CHK: begin
          if (bus.rx_data == (hi_q ^ lo_q)) begin
            instr_d       = {hi_q, lo_q};
            instr_valid_d = 1'b1;
          end else begin
            drop = 1'b1;
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end else if ((state_q != HUNT) && (cnt_q == TO_LAST)) begin
      // Sender stalled mid-frame for too long.
      state_d = HUNT;
      drop    = 1'b1;
    end

    if (drop) begin
      frame_err_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    // Idle counter: zero in HUNT and after each accepted byte, otherwise it
    // counts the empty cycles since the last byte of the frame.
    if ((state_d == HUNT) || byte_ok) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // busy mirrors the registered state so it drops with the final pulse.
  always_comb begin
    busy_d = (state_d != HUNT);
  end

  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_count   = err_count_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_instr_assembler.sv
// Testbench for uart_instr_assembler: table of directed vectors with
// hand-derived expectations, hand-written multi-cycle corner cases, and
// randomized frames checked every cycle against a queue-based frame model.
module tb_uart_instr_assembler;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 8;

  logic clock;
  logic reset_n;

  uart_instr_assembler_if bus_if();

  uart_instr_assembler #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Frame in progress = bytes collected so far (sync first); empty = hunting.
  logic [7:0]  mf[$];
  int          m_idle;
  logic [15:0] m_instr;
  int          m_cnt;
  logic        m_valid;
  logic        m_ferr;

  task automatic mdl_reset();
    mf.delete();
    m_idle  = 0;
    m_instr = 16'h0000;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic mdl_step(input logic v, input logic [7:0] d, input logic e);
    bit dropped;
    dropped = 0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (e) begin
      if (mf.size() > 0) dropped = 1;
      mf.delete();
      m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (mf.size() > 0 || d == SYNC) mf.push_back(d);
      if (mf.size() == 4) begin
        if (mf[3] == (mf[1] ^ mf[2])) begin
          m_instr = {mf[1], mf[2]};
          m_valid = 1'b1;
        end else begin
          dropped = 1;
        end
        mf.delete();
      end
    end else if (mf.size() > 0) begin
      if (m_idle == TO - 1) begin
        dropped = 1;
        mf.delete();
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if (dropped) begin
      m_ferr = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {5'd0, bus_if.instr_valid, bus_if.frame_err, bus_if.instr,
            bus_if.err_count, bus_if.busy};
  endfunction

  function automatic logic [31:0] mdl_vec();
    logic [7:0] c;
    c = m_cnt[7:0];
    return {5'd0, m_valid, m_ferr, m_instr, c, (mf.size() > 0)};
  endfunction

  // One clock: drive inputs just after an edge, advance model at the edge,
  // sample 1 time unit after it. Prints one line per transaction.
  task automatic cycle(input logic v, input logic [7:0] d, input logic e);
    bus_if.rx_valid = v;
    bus_if.rx_data  = d;
    bus_if.rx_err   = e;
    @(posedge clock);
    mdl_step(v, d, e);
    #1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_err   = 1'b0;
    if (v || e)
      $display("[TB] t=%0t v=%0b d=%h e=%0b -> iv=%0b fe=%0b instr=%h cnt=%0d busy=%0b",
               $time, v, d, e, bus_if.instr_valid, bus_if.frame_err,
               bus_if.instr, bus_if.err_count, bus_if.busy);
    check("model", dut_vec(), mdl_vec());
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        e;
    logic        ev;
    logic        ef;
    logic [15:0] ei;
    logic [7:0]  ec;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic e, logic ev,
                              logic ef, logic [15:0] ei, logic [7:0] ec, logic eb);
    vec_t r;
    r.v = v; r.d = d; r.e = e; r.ev = ev; r.ef = ef; r.ei = ei; r.ec = ec; r.eb = eb;
    return r;
  endfunction

  // Random frame traffic
  task automatic send(input logic [7:0] d);
    int gap;
    gap = $urandom_range(0, 2);
    if ($urandom_range(0, 19) == 0) gap = $urandom_range(7, 9);
    idle(gap);
    if ($urandom_range(0, 39) == 0) cycle(1'b0, 8'h00, 1'b1);
    if ($urandom_range(0, 39) == 0) cycle(1'b1, d, 1'b1);
    else                            cycle(1'b1, d, 1'b0);
  endtask

  initial begin
    logic [7:0] hi, lo, ck;
    bit seen_err, seen_valid;

    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_err   = 1'b0;
    reset_n         = 1'b0;
    mdl_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", dut_vec(), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    //            v  d      e  ev ef instr     cnt  busy
    // good frame with idle gaps
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 16'h0000, 8'd0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'h0000, 8'd0, 1));
    tbl.push_back(mk(1, 8'h12, 0, 0, 0, 16'h0000, 8'd0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'h0000, 8'd0, 1));
    tbl.push_back(mk(1, 8'h34, 0, 0, 0, 16'h0000, 8'd0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'h0000, 8'd0, 1));
    tbl.push_back(mk(1, 8'h26, 0, 1, 0, 16'h1234, 8'd0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'h1234, 8'd0, 0));
    // bad checksum, then immediately a good frame
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 16'h1234, 8'd0, 1));
    tbl.push_back(mk(1, 8'h12, 0, 0, 0, 16'h1234, 8'd0, 1));
    tbl.push_back(mk(1, 8'h34, 0, 0, 0, 16'h1234, 8'd0, 1));
    tbl.push_back(mk(1, 8'h00, 0, 0, 1, 16'h1234, 8'd1, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 16'h1234, 8'd1, 1));
    tbl.push_back(mk(1, 8'hAB, 0, 0, 0, 16'h1234, 8'd1, 1));
    tbl.push_back(mk(1, 8'hCD, 0, 0, 0, 16'h1234, 8'd1, 1));
    tbl.push_back(mk(1, 8'h66, 0, 1, 0, 16'hABCD, 8'd1, 0));
    // hunt junk, sync-valued data byte
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 16'hABCD, 8'd1, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 16'hABCD, 8'd1, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 16'hABCD, 8'd1, 1));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 16'hABCD, 8'd1, 1));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 16'hABCD, 8'd1, 1));
    tbl.push_back(mk(1, 8'hA5, 0, 1, 0, 16'hA500, 8'd1, 0));
    // rx_err in WAIT_LO
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 16'hA500, 8'd1, 1));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 16'hA500, 8'd1, 1));
    tbl.push_back(mk(1, 8'h22, 1, 0, 1, 16'hA500, 8'd2, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'hA500, 8'd2, 0));
    // rx_err alone while hunting: silent
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 16'hA500, 8'd2, 0));
    // rx_err on the checksum byte wins over a matching checksum
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 16'hA500, 8'd2, 1));
    tbl.push_back(mk(1, 8'h01, 0, 0, 0, 16'hA500, 8'd2, 1));
    tbl.push_back(mk(1, 8'h02, 0, 0, 0, 16'hA500, 8'd2, 1));
    tbl.push_back(mk(1, 8'h03, 1, 0, 1, 16'hA500, 8'd3, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].e);
      check($sformatf("tbl[%0d]", i), dut_vec(),
            {5'd0, tbl[i].ev, tbl[i].ef, tbl[i].ei, tbl[i].ec, tbl[i].eb});
    end

    // Timeout: A5, 12, then silence; frame_err after the 8th idle edge.
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      idle(1);
      check($sformatf("timeout_k%0d", k), {30'd0, bus_if.frame_err, bus_if.busy},
            (k == TO) ? 32'd2 : 32'd1);
    end
    check("timeout_cnt", {24'd0, bus_if.err_count}, 32'd4);

    // Byte arrives exactly when the timeout would fire: frame survives.
    seen_err = 0;
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    for (int k = 0; k < TO - 1; k++) begin idle(1); seen_err |= bus_if.frame_err; end
    cycle(1'b1, 8'h34, 1'b0);
    seen_err |= bus_if.frame_err;
    for (int k = 0; k < TO - 1; k++) begin idle(1); seen_err |= bus_if.frame_err; end
    cycle(1'b1, 8'h26, 1'b0);
    check("late_byte_no_err", {31'd0, seen_err}, 32'd0);
    check("late_byte_instr", {15'd0, bus_if.instr_valid, bus_if.instr}, 32'h1_1234);

    // 300 bad frames back to back: counter saturates, pulses continue.
    for (int f = 0; f < 300; f++) begin
      cycle(1'b1, 8'hA5, 1'b0);
      cycle(1'b1, 8'h00, 1'b0);
      cycle(1'b1, 8'h00, 1'b0);
      cycle(1'b1, 8'h01, 1'b0);
    end
    check("sat_cnt", {23'd0, bus_if.frame_err, bus_if.err_count}, 32'h1FF);

    // Reset mid-frame: outputs clear at once, partial frame is lost.
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'hCC, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), 32'h0);
    mdl_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    cycle(1'b1, 8'h34, 1'b0);
    cycle(1'b1, 8'hF8, 1'b0);
    check("post_reset_lost", dut_vec(), 32'h0);

    // Randomized frames against the model.
    seen_valid = 0;
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 4) == 0) send(8'($urandom));
      hi = 8'($urandom);
      lo = 8'($urandom);
      ck = hi ^ lo;
      if ($urandom_range(0, 3) == 0) ck = ck ^ (8'h01 << $urandom_range(0, 7));
      send(SYNC);
      send(hi);
      send(lo);
      send(ck);
      seen_valid |= bus_if.instr_valid;
    end
    idle(TO + 2);
    check("random_saw_valid", {31'd0, seen_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_instr_assembler.md
# uart_instr_assembler

Byte-to-instruction framer between the UART receive byte engine and the `Core` instruction port. It hunts for a sync byte and collects a 16-bit instruction (high byte first) plus an XOR checksum. On a good frame it emits a one-cycle `instr_valid` pulse with `instr`. Corrupt, aborted or stalled frames are dropped, flagged and counted.

## Interface

Parameters:
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 50000: idle clocks allowed between bytes inside a frame; must be ≥ 2.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte; sampled only when `rx_valid`=1.
- `rx_err`  in  1  one-cycle strobe: UART framing/overrun error on the current byte.
- `instr_valid`  out  1  one-cycle pulse: `instr` holds a new checked instruction.
- `instr`  out  16  last good instruction; holds between pulses.
- `frame_err`  out  1  one-cycle pulse: a frame was discarded.
- `err_count`  out  8  discarded-frame count, saturating at 255.
- `busy`  out  1  high while a frame is in progress (state ≠ HUNT).

## Operation

- Frame format: `SYNC_BYTE`, `HI`, `LO`, `CHK`. The frame is good when `CHK == HI ^ LO`. On a good frame, `instr = {HI, LO}`.
- States: HUNT, WAIT_HI, WAIT_LO, WAIT_CHK.
- HUNT:
  - byte == `SYNC_BYTE` → WAIT_HI.
  - Any other byte is discarded silently (no error).
- WAIT_HI: any byte is latched as HI → WAIT_LO. A byte equal to `SYNC_BYTE` is still data, with no resync.
- WAIT_LO: latch LO → WAIT_CHK.
- WAIT_CHK:
  - Checksum match → load `instr`, pulse `instr_valid`, go to HUNT.
  - Mismatch → pulse `frame_err`, increment `err_count`, go to HUNT.
- `rx_err` with `rx_valid` in any state: the byte is ignored and the state goes to HUNT. Outside HUNT this also pulses `frame_err` and increments `err_count`. In HUNT it has no effect besides staying in HUNT.
- `rx_err` without `rx_valid`: handled as above.
- Timeout:
  - A counter clears on every accepted byte and on entry to HUNT.
  - Outside HUNT it increments each cycle with no `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES-1` with no byte that cycle: go to HUNT, pulse `frame_err`, increment `err_count`.
  - Counter width: `$clog2(TIMEOUT_CYCLES)`.
- `err_count` saturates at 8'hFF; further errors still pulse `frame_err`.
- At most one of `instr_valid` and `frame_err` is high in any cycle.

## Timing

- Reset (async assert, released synchronously by `clock`):
  - state = HUNT
  - `instr_valid` = 0, `frame_err` = 0
  - `instr` = 16'h0000
  - `err_count` = 0, `busy` = 0
  - timeout counter = 0
- All outputs are registered.
- Latency: CHK byte accepted on edge N → `instr_valid`/`frame_err` high for exactly cycle N+1, `busy` low from N+1.
- Back-to-back bytes (`rx_valid` every cycle) are fully supported. A new SYNC may arrive in the cycle in which `instr_valid` is high.
- Byte and timeout in the same cycle: the byte wins and the counter clears.
- `rx_err` and a checksum byte in the same cycle: `rx_err` wins, giving one `frame_err` and no `instr_valid`.
- Reset mid-frame: the partial frame is lost, with no pulse. `err_count` and `instr` are cleared.

## Test plan

- Good frame: A5, 12, 34, 26 with one idle cycle between bytes → `instr_valid` for one cycle after the 26 byte, `instr` = 16'h1234, `err_count` = 0.
- Bad checksum: A5, 12, 34, 00 → one `frame_err` pulse, `err_count` = 1, `instr` unchanged. The immediately following A5, AB, CD, 66 yields `instr` = 16'hABCD.
- Hunt/data-sync: 00, FF, A5, A5, 00, A5 (back-to-back) → leading 00/FF ignored, `instr` = 16'hA500, `busy` high from the first A5 until the pulse.
- Timeout with `TIMEOUT_CYCLES` = 8: A5, 12, then silence → `frame_err` exactly 8 cycles after the 12 byte, state back to HUNT.
- Byte arrives on the cycle timeout would fire → no error, frame completes normally.
- Errors and reset:
  - `rx_err` during WAIT_LO → `frame_err`, `err_count` +1.
  - 300 bad frames → `err_count` holds 255.
  - Assert `reset_n` low mid-frame → all outputs 0 immediately.
